// File: rtl/jesd_8b10b_pkg.sv
// Shared 8b/10b definitions: running-disparity encoding, K28.5 symbols,
// sub-block disparity classification and the RD sequencing step.
package jesd_8b10b_pkg;

    localparam logic RD_MINUS = 1'b0;
    localparam logic RD_PLUS  = 1'b1;

    localparam logic [7:0] K28_5_BYTE     = 8'hBC;
    localparam logic [9:0] K28_5_RD_MINUS = 10'h0FA;
    localparam logic [9:0] K28_5_RD_PLUS  = 10'h305;

    typedef enum logic [1:0] {
        DISP_NEG  = 2'd0,
        DISP_ZERO = 2'd1,
        DISP_POS  = 2'd2,
        DISP_INV  = 2'd3
    } disp_t;

    // mid is the balanced ones-count of the sub-block (3 for 6b, 2 for 4b)
    function automatic disp_t sub_disp(input int ones, input int mid);
        if (ones == mid - 1)      return DISP_NEG;
        else if (ones == mid)     return DISP_ZERO;
        else if (ones == mid + 1) return DISP_POS;
        else                      return DISP_INV;
    endfunction

    // Returns {disp_err, rd_after}; a wrong-signed sub-block resyncs RD to its sign
    function automatic logic [1:0] rd_step(input logic rd, input disp_t disp);
        case (disp)
            DISP_POS: return {rd == RD_PLUS, RD_PLUS};
            DISP_NEG: return {rd == RD_MINUS, RD_MINUS};
            default:  return {1'b0, rd};
        endcase
    endfunction

endpackage

// File: rtl/decoder_lut_8b10b.sv
// Combinational 10b -> 8b table lookup: decoded byte, K flag, code error and
// the disparity class of the 6b and 4b sub-blocks.
module decoder_lut_8b10b
    import jesd_8b10b_pkg::*;
(
    input  logic [9:0] sym,
    output logic [7:0] data,
    output logic       k,
    output logic       code_err,
    output disp_t      disp6,
    output disp_t      disp4
);

    logic [5:0] six;
    logic [3:0] four;
    logic [3:0] four_eff;
    logic [4:0] x;
    logic [2:0] y;
    logic       ok6;
    logic       ok4;
    logic       a7;
    logic       is_k28;
    logic       k7;
    logic       a7_legal;

    assign six   = sym[9:4];
    assign four  = sym[3:0];
    assign disp6 = sub_disp($countones(six), 3);
    assign disp4 = sub_disp($countones(four), 2);

    // K28 in its RD+ form carries the complemented 4b code
    assign is_k28   = (six == 6'b001111) || (six == 6'b110000);
    assign four_eff = (six == 6'b110000) ? ~four : four;

    always_comb begin
        // NOTE: defaults assigned first so every path drives every output and no latch is inferred.
        x   = 5'd0;
        ok6 = 1'b1;
        case (six)
            6'b100111, 6'b011000: x = 5'd0;
            6'b011101, 6'b100010: x = 5'd1;
            6'b101101, 6'b010010: x = 5'd2;
            6'b110001:            x = 5'd3;
            6'b110101, 6'b001010: x = 5'd4;
            6'b101001:            x = 5'd5;
            6'b011001:            x = 5'd6;
            6'b111000, 6'b000111: x = 5'd7;
            6'b111001, 6'b000110: x = 5'd8;
            6'b100101:            x = 5'd9;
            6'b010101:            x = 5'd10;
            6'b110100:            x = 5'd11;
            6'b001101:            x = 5'd12;
            6'b101100:            x = 5'd13;
            6'b011100:            x = 5'd14;
            6'b010111, 6'b101000: x = 5'd15;
            6'b011011, 6'b100100: x = 5'd16;
            6'b100011:            x = 5'd17;
            6'b010011:            x = 5'd18;
            6'b110010:            x = 5'd19;
            6'b001011:            x = 5'd20;
            6'b101010:            x = 5'd21;
            6'b011010:            x = 5'd22;
            6'b111010, 6'b000101: x = 5'd23;
            6'b110011, 6'b001100: x = 5'd24;
            6'b100110:            x = 5'd25;
            6'b010110:            x = 5'd26;
            6'b110110, 6'b001001: x = 5'd27;
            6'b001110, 6'b001111,
            6'b110000:            x = 5'd28;
            6'b101110, 6'b010001: x = 5'd29;
            6'b011110, 6'b100001: x = 5'd30;
            6'b101011, 6'b010100: x = 5'd31;
            default:              ok6 = 1'b0;
        endcase
    end

    always_comb begin
        y   = 3'd0;
        ok4 = 1'b1;
        a7  = 1'b0;
        case (four_eff)
            4'b1011, 4'b0100: y = 3'd0;
            4'b1001:          y = 3'd1;
            4'b0101:          y = 3'd2;
            4'b1100, 4'b0011: y = 3'd3;
            4'b1101, 4'b0010: y = 3'd4;
            4'b1010:          y = 3'd5;
            4'b0110:          y = 3'd6;
            4'b1110, 4'b0001: y = 3'd7;
            4'b0111, 4'b1000: begin
                y  = 3'd7;
                a7 = 1'b1;
            end
            default:          ok4 = 1'b0;
        endcase
    end

    // Alternate x.7 is only legal as K23/27/29/30.7 or the six D.x.A7 pairings
    assign k7       = a7 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
    assign a7_legal = (four == 4'b0111 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                      (four == 4'b1000 && (x == 5'd11 || x == 5'd13 || x == 5'd14));

    always_comb begin
        code_err = !ok6 || !ok4 || (a7 && !is_k28 && !k7 && !a7_legal);
        k        = !code_err && (is_k28 || k7);
        data     = code_err ? 8'h00 : {y, x};
    end

endmodule

// File: rtl/decoder_8b10b.sv
// Two-stage 8b/10b decoder with running-disparity tracking and error flags.
// Define DECODER_8B10B_ERR_CNT_EN to add saturating code/disparity error counters.
module decoder_8b10b
    import jesd_8b10b_pkg::*;
#(
    parameter logic RD_INIT = 1'b0
`ifdef DECODER_8B10B_ERR_CNT_EN
    ,
    parameter int unsigned ERR_CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DECODER_8B10B_ERR_CNT_EN
    input  logic                 i_cnt_clr,
    output logic [ERR_CNT_W-1:0] o_code_err_cnt,
    output logic [ERR_CNT_W-1:0] o_disp_err_cnt,
`endif
    input  logic [9:0]           i_data,
    input  logic                 i_vld,
    output logic [7:0]           o_data,
    output logic                 o_k,
    output logic                 o_vld,
    output logic                 o_code_err,
    output logic                 o_disp_err,
    output logic                 o_rd
);

    logic [9:0] sym_q;
    logic       vld_q;
    logic [7:0] lut_data;
    logic       lut_k;
    logic       lut_code_err;
    disp_t      disp6;
    disp_t      disp4;
    logic [1:0] step6;
    logic [1:0] step4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_q <= '0;
            vld_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            sym_q <= i_data;
            vld_q <= i_vld;
        end
    end

    decoder_lut_8b10b u_lut (
        .sym      (sym_q),
        .data     (lut_data),
        .k        (lut_k),
        .code_err (lut_code_err),
        .disp6    (disp6),
        .disp4    (disp4)
    );

    // 4b sub-block is judged against the RD left behind by the 6b sub-block
    assign step6 = rd_step(o_rd, disp6);
    assign step4 = rd_step(step6[0], disp4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data     <= 8'h00;
            o_k        <= 1'b0;
            o_vld      <= 1'b0;
            o_code_err <= 1'b0;
            o_disp_err <= 1'b0;
            o_rd       <= RD_INIT;
        end else begin
            o_vld      <= vld_q;
            o_code_err <= vld_q && lut_code_err;
            o_disp_err <= vld_q && (step6[1] || step4[1]);
            if (vld_q) begin
                o_data <= lut_data;
                o_k    <= lut_k;
                o_rd   <= step4[0];
            end
        end
    end

`ifdef DECODER_8B10B_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_code_err_cnt <= '0;
            o_disp_err_cnt <= '0;
        end else if (i_cnt_clr) begin
            o_code_err_cnt <= '0;
            o_disp_err_cnt <= '0;
        end else begin
            if (o_vld && o_code_err && !(&o_code_err_cnt))
                o_code_err_cnt <= o_code_err_cnt + 1'b1;
            if (o_vld && o_disp_err && !(&o_disp_err_cnt))
                o_disp_err_cnt <= o_disp_err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_8b10b.sv
// Scoreboard bench for decoder_8b10b: a reference 8b/10b encoder generates
// legal streams, hand-built symbols cover error cases and reset behaviour.
module tb_decoder_8b10b;
    import jesd_8b10b_pkg::*;

    localparam logic TB_RD_INIT = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] i_data = '0;
    logic       i_vld = 1'b0;
    logic [7:0] o_data;
    logic       o_k;
    logic       o_vld;
    logic       o_code_err;
    logic       o_disp_err;
    logic       o_rd;
`ifdef DECODER_8B10B_ERR_CNT_EN
    logic       i_cnt_clr = 1'b0;
    logic [1:0] o_code_err_cnt;
    logic [1:0] o_disp_err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic        m_rd = TB_RD_INIT;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;
    logic [11:0] mon_o;

    always #5 clk = ~clk;

    decoder_8b10b #(
        .RD_INIT   (TB_RD_INIT)
`ifdef DECODER_8B10B_ERR_CNT_EN
        ,
        .ERR_CNT_W (2)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef DECODER_8B10B_ERR_CNT_EN
        .i_cnt_clr      (i_cnt_clr),
        .o_code_err_cnt (o_code_err_cnt),
        .o_disp_err_cnt (o_disp_err_cnt),
`endif
        .i_data         (i_data),
        .i_vld          (i_vld),
        .o_data         (o_data),
        .o_k            (o_k),
        .o_vld          (o_vld),
        .o_code_err     (o_code_err),
        .o_disp_err     (o_disp_err),
        .o_rd           (o_rd)
    );

    // Reference encoder: RD- column codes, complemented when the sub-block starts at RD+
    function automatic logic [5:0] enc6(input logic [4:0] x);
        case (x)
            5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
            5'd10: return 6'b010101;  5'd11: return 6'b110100;
            5'd12: return 6'b001101;  5'd13: return 6'b101100;
            5'd14: return 6'b011100;  5'd15: return 6'b010111;
            5'd16: return 6'b011011;  5'd17: return 6'b100011;
            5'd18: return 6'b010011;  5'd19: return 6'b110010;
            5'd20: return 6'b001011;  5'd21: return 6'b101010;
            5'd22: return 6'b011010;  5'd23: return 6'b111010;
            5'd24: return 6'b110011;  5'd25: return 6'b100110;
            5'd26: return 6'b010110;  5'd27: return 6'b110110;
            5'd28: return 6'b001110;  5'd29: return 6'b101110;
            5'd30: return 6'b011110;  default: return 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] enc4(input logic [2:0] y, input logic k28);
        logic [3:0] d_tbl [8];
        logic [3:0] k_tbl [8];
        d_tbl = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        k_tbl = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
        return k28 ? k_tbl[y] : d_tbl[y];
    endfunction

    // Returns {rd_after, symbol}
    function automatic logic [10:0] encode(input logic [7:0] b, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd6;
        logic       alt;
        x  = b[4:0];
        y  = b[7:5];
        c6 = (k && x == 5'd28) ? 6'b001111 : enc6(x);
        if (rd && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
        rd6 = ($countones(c6) == 3) ? rd : ~rd;
        if (k && x == 5'd28) begin
            c4 = enc4(y, 1'b1);
            if (rd) c4 = ~c4;
        end else begin
            alt = (y == 3'd7) && (k || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                                      (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
            c4 = alt ? 4'b0111 : enc4(y, 1'b0);
            if (rd6 && ($countones(c4) != 2 || c4 == 4'b1100)) c4 = ~c4;
        end
        return {($countones(c4) == 2) ? rd6 : ~rd6, c6, c4};
    endfunction

    // Scoreboard monitor: every o_vld must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && o_vld) begin
            n_vec++;
            mon_o = {o_data, o_k, o_code_err, o_disp_err, o_rd};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_vld: got data=%h k=%b ce=%b de=%b rd=%b, no symbol pending",
                         o_data, o_k, o_code_err, o_disp_err, o_rd);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_o !== mon_e) begin
                    n_err++;
                    $display("FAIL decode: got data=%h k=%b ce=%b de=%b rd=%b, want data=%h k=%b ce=%b de=%b rd=%b",
                             mon_o[11:4], mon_o[3], mon_o[2], mon_o[1], mon_o[0],
                             mon_e[11:4], mon_e[3], mon_e[2], mon_e[1], mon_e[0]);
                end
            end
        end
    end

    task automatic drive(input logic [9:0] sym, input logic vld);
        @(posedge clk);
        #1;
        i_data = sym;
        i_vld  = vld;
    endtask

    task automatic send(input logic [9:0] sym, input logic [7:0] d, input logic k,
                        input logic ce, input logic de, input logic rd);
        exp_q.push_back({d, k, ce, de, rd});
        m_rd = rd;
        drive(sym, 1'b1);
    endtask

    task automatic send_enc(input logic [7:0] b, input logic k);
        logic [10:0] r;
        r = encode(b, k, m_rd);
        send(r[9:0], b, k, 1'b0, 1'b0, r[10]);
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(10'h000, 1'b0);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d symbols still pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        i_vld = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_rd = TB_RD_INIT;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({o_data, o_k, o_vld, o_code_err, o_disp_err, o_rd} !== {8'h00, 4'b0000, TB_RD_INIT}) begin
            n_err++;
            $display("FAIL reset_state: got data=%h k=%b vld=%b ce=%b de=%b rd=%b, want 00/0/0/0/0/%b",
                     o_data, o_k, o_vld, o_code_err, o_disp_err, o_rd, TB_RD_INIT);
        end
        rst = 1'b0;
    endtask

    task automatic test_k28_5;
        send(K28_5_RD_MINUS, K28_5_BYTE, 1'b1, 1'b0, 1'b0, RD_PLUS);
        send(K28_5_RD_PLUS,  K28_5_BYTE, 1'b1, 1'b0, 1'b0, RD_MINUS);
        send(10'h2AA, 8'hB5, 1'b0, 1'b0, 1'b0, RD_MINUS);
        drain();
    endtask

    task automatic test_d0_0;
        send(10'h274, 8'h00, 1'b0, 1'b0, 1'b0, RD_MINUS);
        drain();
    endtask

    task automatic test_back_to_back;
        logic [7:0] k_list [12];
        k_list = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                   8'hF7, 8'hFB, 8'hFD, 8'hFE};
        for (int b = 0; b < 256; b++) send_enc(b[7:0], 1'b0);
        for (int i = 0; i < 12; i++) send_enc(k_list[i], 1'b1);
        for (int i = 0; i < 200; i++) send_enc(8'($urandom_range(255)), 1'b0);
        for (int i = 0; i < 24; i++) send_enc(k_list[i % 12], 1'b1);
        drain();
    endtask

    task automatic test_idle_hold;
        send_enc(8'h4A, 1'b0);
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(10'h3FF, 1'b0);
            n_vec++;
            if ({o_vld, o_data, o_k, o_rd} !== {1'b0, 8'h4A, 1'b0, m_rd}) begin
                n_err++;
                $display("FAIL idle_hold: got vld=%b data=%h k=%b rd=%b, want 0/4a/0/%b",
                         o_vld, o_data, o_k, o_rd, m_rd);
            end
        end
    endtask

    task automatic test_disp_err;
        do_reset();
        send(K28_5_RD_MINUS, K28_5_BYTE, 1'b1, 1'b0, 1'b0, RD_PLUS);
        send(K28_5_RD_MINUS, K28_5_BYTE, 1'b1, 1'b0, 1'b1, RD_PLUS);
        drain();
    endtask

    task automatic test_code_err;
        send(10'h000, 8'h00, 1'b0, 1'b1, 1'b0, RD_PLUS);
        send(10'h0FF, 8'h00, 1'b0, 1'b1, 1'b1, RD_PLUS);
        send(10'h1D7, 8'h00, 1'b0, 1'b1, 1'b1, RD_PLUS);
        send(10'h300, 8'h00, 1'b0, 1'b1, 1'b0, RD_MINUS);
        send(10'h3C5, 8'h00, 1'b0, 1'b1, 1'b0, RD_PLUS);
        send(10'h347, 8'h00, 1'b0, 1'b1, 1'b1, RD_PLUS);
        drain();
    endtask

    task automatic test_reset_midstream;
        drive(K28_5_RD_PLUS, 1'b1);
        drive(10'h2AA, 1'b1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        i_vld = 1'b0;
        m_rd  = TB_RD_INIT;
        n_vec++;
        if ({o_vld, o_rd} !== {1'b0, TB_RD_INIT}) begin
            n_err++;
            $display("FAIL midreset_state: got vld=%b rd=%b, want 0/%b", o_vld, o_rd, TB_RD_INIT);
        end
        for (int i = 0; i < 3; i++) begin
            drive(10'h000, 1'b0);
            n_vec++;
            if (o_vld !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_flush: got vld=%b, want 0", o_vld);
            end
        end
        send(K28_5_RD_MINUS, K28_5_BYTE, 1'b1, 1'b0, 1'b0, RD_PLUS);
        drive(10'h000, 1'b0);
        n_vec++;
        if (o_vld !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got vld=%b one cycle after input, want 0", o_vld);
        end
        drive(10'h000, 1'b0);
        n_vec++;
        if (o_vld !== 1'b1) begin
            n_err++;
            $display("FAIL latency_two: got vld=%b two cycles after input, want 1", o_vld);
        end
        drain();
    endtask

`ifdef DECODER_8B10B_ERR_CNT_EN
    task automatic test_err_cnt;
        do_reset();
        for (int i = 0; i < 3; i++) send(10'h000, 8'h00, 1'b0, 1'b1, 1'b0, m_rd);
        drain();
        drive(10'h000, 1'b0);
        n_vec++;
        if ({o_code_err_cnt, o_disp_err_cnt} !== {2'd3, 2'd0}) begin
            n_err++;
            $display("FAIL cnt_three: got code=%0d disp=%0d, want 3/0", o_code_err_cnt, o_disp_err_cnt);
        end
        i_cnt_clr = 1'b1;
        drive(10'h000, 1'b0);
        i_cnt_clr = 1'b0;
        n_vec++;
        if (o_code_err_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL cnt_clear: got code=%0d, want 0", o_code_err_cnt);
        end
        for (int i = 0; i < 5; i++) send(10'h000, 8'h00, 1'b0, 1'b1, 1'b0, m_rd);
        drain();
        drive(10'h000, 1'b0);
        n_vec++;
        if (o_code_err_cnt !== 2'd3) begin
            n_err++;
            $display("FAIL cnt_saturate: got code=%0d, want 3", o_code_err_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_k28_5();
        test_d0_0();
        test_back_to_back();
        test_idle_hold();
        test_disp_err();
        test_code_err();
        test_reset_midstream();
`ifdef DECODER_8B10B_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
